dmem_dump_arbiter: RTL and testbench
====================================

DMEM_DUMP_ARBITER -- requirements
Module: dmem_dump_arbiter

Interface
REQ-001 Parameter INST_SZ, default 32, data/address width of pipeline and dump ports.
REQ-002 Parameter MEM_ADDR_W, default 5, data-memory word-address width; depth DEPTH = 2**MEM_ADDR_W.
REQ-003 i_clk  in  1  clock, all state updates on rising edge.
REQ-004 i_reset  in  1  asynchronous, active-low reset.
REQ-005 i_halt  in  1  pipeline halted; dump may start only while high.
REQ-006 i_pipe_mem_read / i_pipe_mem_write  in  1 each  MEM-stage control lines.
REQ-007 i_pipe_addr  in  INST_SZ  byte address (ALU result); i_pipe_wdata  in  INST_SZ  store data.
REQ-008 i_dump_start  in  1  dump request pulse; i_dump_ready  in  1  consumer ready.
REQ-009 i_mem_rdata  in  INST_SZ  data-memory read data, valid one cycle after o_mem_read.
REQ-010 o_mem_read / o_mem_write  out  1 each; o_mem_addr  out  MEM_ADDR_W; o_mem_wdata  out  INST_SZ.
REQ-011 o_pipe_rdata  out  INST_SZ  read data returned to MEM stage.
REQ-012 o_dump_data  out  INST_SZ; o_dump_addr  out  MEM_ADDR_W; o_dump_valid  out  1.
REQ-013 o_dump_done  out  1  one-cycle completion pulse; o_busy  out  1  dump in progress; o_pipe_stall  out  1.

Function
REQ-014 FSM states: IDLE, ISSUE, CAPTURE, SEND, DONE.
REQ-015 IDLE: memory port owned by pipeline; o_mem_read/o_mem_write = pipe lines, o_mem_addr = i_pipe_addr[MEM_ADDR_W+1:2], o_mem_wdata = i_pipe_wdata, combinational.
REQ-016 o_pipe_rdata = i_mem_rdata at all times; o_pipe_stall = 0 in IDLE.
REQ-017 IDLE -> ISSUE when i_dump_start=1 and i_halt=1; counter cleared to 0; i_dump_start with i_halt=0 ignored.
REQ-018 ISSUE: o_mem_read=1, o_mem_write=0, o_mem_addr=counter; next state CAPTURE.
REQ-019 CAPTURE: register i_mem_rdata into o_dump_data, counter into o_dump_addr; next state SEND.
REQ-020 SEND: o_dump_valid=1, o_dump_data/o_dump_addr held stable until i_dump_ready=1 in the same cycle.
REQ-021 SEND handshake: counter==DEPTH-1 -> DONE, else counter+1 -> ISSUE; minimum 3 cycles per word.
REQ-022 DONE: o_dump_done=1 for exactly one cycle, then IDLE; counter never wraps past DEPTH-1.
REQ-023 Non-IDLE states: o_busy=1, o_pipe_stall=1, pipeline read/write requests ignored, o_mem_write=0.
REQ-024 i_halt falling in any non-IDLE state: abort to IDLE next cycle, no o_dump_done, o_dump_valid low.
REQ-025 i_dump_start while non-IDLE: ignored.
REQ-026 Memory outputs in CAPTURE/SEND/DONE: o_mem_read=0, o_mem_write=0.

Reset
REQ-027 i_reset=0 forces IDLE, counter=0, o_dump_data=0, o_dump_addr=0, o_dump_valid=0, o_dump_done=0, o_busy=0, o_pipe_stall=0, immediately without clock.
REQ-028 Reset mid-dump discards the dump; no done pulse after release.

Configuration
REQ-029 Macro DMEM_ADDR_CHECK_EN defined: output o_addr_err (1 bit) added; pipeline access with i_pipe_addr[1:0]!=0 or nonzero bits above MEM_ADDR_W+1 sets o_addr_err sticky (cleared only by reset) and forces o_mem_write=0 that cycle.
REQ-030 Macro undefined: port o_addr_err absent; pipeline accesses pass through unchecked, upper and low address bits ignored.

Verification
REQ-031 i_halt=0, i_pipe_mem_write=1, addr=0x0C, data=0xDEADBEEF -> o_mem_write=1, o_mem_addr=3, o_mem_wdata=0xDEADBEEF same cycle.
REQ-032 Memory preloaded mem[k]=k*4, i_halt=1, i_dump_start pulse, i_dump_ready=1 -> 32 valid beats, o_dump_addr 0..31, data 0..124, o_dump_done pulse at cycle 97 after start.
REQ-033 Dump with i_dump_ready low 5 cycles at word 7 -> o_dump_valid held, o_dump_data=28 stable, no word skipped or duplicated.
REQ-034 i_halt dropped while o_dump_addr=10 -> IDLE next cycle, o_busy=0, no o_dump_done; pipeline write during dump never reaches o_mem_write.
REQ-035 i_reset asserted during SEND -> all outputs zero asynchronously; i_dump_start with i_halt=0 after release -> stays IDLE.
REQ-036 DMEM_ADDR_CHECK_EN, pipe write to 0x0000_0102 -> o_mem_write=0, o_addr_err=1 and held until reset.

Source files
------------

// File: rtl/dmem_dump_arbiter.sv
// Data-memory port arbiter: the pipeline owns the port in IDLE; while halted, a dump walks every word out
// over a valid/ready stream. Optional address checking is enabled by defining DMEM_ADDR_CHECK_EN.
module dmem_dump_arbiter #(
  parameter int unsigned INST_SZ    = 32,
  parameter int unsigned MEM_ADDR_W = 5
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_halt,
  input  logic                  i_pipe_mem_read,
  input  logic                  i_pipe_mem_write,
  input  logic [INST_SZ-1:0]    i_pipe_addr,
  input  logic [INST_SZ-1:0]    i_pipe_wdata,
  input  logic                  i_dump_start,
  input  logic                  i_dump_ready,
  input  logic [INST_SZ-1:0]    i_mem_rdata,
  output logic                  o_mem_read,
  output logic                  o_mem_write,
  output logic [MEM_ADDR_W-1:0] o_mem_addr,
  output logic [INST_SZ-1:0]    o_mem_wdata,
  output logic [INST_SZ-1:0]    o_pipe_rdata,
  output logic [INST_SZ-1:0]    o_dump_data,
  output logic [MEM_ADDR_W-1:0] o_dump_addr,
  output logic                  o_dump_valid,
  output logic                  o_dump_done,
  output logic                  o_busy,
`ifdef DMEM_ADDR_CHECK_EN
  output logic                  o_addr_err,
`endif
  output logic                  o_pipe_stall
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_SEND, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [MEM_ADDR_W-1:0] cnt_q, cnt_d;
  logic [INST_SZ-1:0]    dump_data_q;
  logic [MEM_ADDR_W-1:0] dump_addr_q;
  logic                  addr_bad_c;

`ifdef DMEM_ADDR_CHECK_EN
  logic addr_err_q;

  // Misaligned or out-of-range pipeline access while the pipeline owns the port
  assign addr_bad_c = (state_q == S_IDLE) && (i_pipe_mem_read || i_pipe_mem_write) &&
                      ((i_pipe_addr[1:0] != 2'b00) ||
                       ((i_pipe_addr >> (MEM_ADDR_W + 2)) != '0));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)        addr_err_q <= 1'b0;
    else if (addr_bad_c) addr_err_q <= 1'b1;
  end

  assign o_addr_err = addr_err_q;
`else
  logic unused_addr_bits;

  assign addr_bad_c       = 1'b0;
  assign unused_addr_bits = ^{i_pipe_addr[INST_SZ-1:MEM_ADDR_W+2], i_pipe_addr[1:0]};
`endif

  // State, word counter and captured dump beat
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dump_data_q <= '0;
      dump_addr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_CAPTURE) begin
        dump_data_q <= i_mem_rdata;
        dump_addr_q <= cnt_q;
      end
    end
  end

  // Next state and memory-port mux
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    o_mem_read  = 1'b0;
    o_mem_write = 1'b0;
    o_mem_addr  = cnt_q;
    o_mem_wdata = i_pipe_wdata;
    case (state_q)
      S_IDLE: begin
        o_mem_read  = i_pipe_mem_read;
        o_mem_write = i_pipe_mem_write && !addr_bad_c;
        o_mem_addr  = i_pipe_addr[MEM_ADDR_W+1:2];
        if (i_dump_start && i_halt) begin
          state_d = S_ISSUE;
          cnt_d   = '0;
        end
      end
      S_ISSUE: begin
        o_mem_read = 1'b1;
        state_d    = S_CAPTURE;
      end
      S_CAPTURE: state_d = S_SEND;
      S_SEND: begin
        if (i_dump_ready) begin
          if (&cnt_q) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Losing the halt abandons the dump without a completion pulse
    if ((state_q != S_IDLE) && !i_halt) state_d = S_IDLE;
  end

  assign o_pipe_rdata = i_mem_rdata;
  assign o_dump_data  = dump_data_q;
  assign o_dump_addr  = dump_addr_q;
  assign o_dump_valid = (state_q == S_SEND);
  assign o_dump_done  = (state_q == S_DONE);
  assign o_busy       = (state_q != S_IDLE);
  assign o_pipe_stall = (state_q != S_IDLE);

endmodule

// File: tb/tb_dmem_dump_arbiter.sv
// Bench for dmem_dump_arbiter: word-array memory model, pipeline pass-through, randomized dump streams,
// abort and reset scenarios. Define DMEM_ADDR_CHECK_EN to also exercise the address checker.
module tb_dmem_dump_arbiter;
  localparam int unsigned INST_SZ    = 32;
  localparam int unsigned MEM_ADDR_W = 5;
  localparam int unsigned DEPTH      = 32;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  halt = 1'b0;
  logic                  pipe_re = 1'b0;
  logic                  pipe_we = 1'b0;
  logic [INST_SZ-1:0]    pipe_addr = '0;
  logic [INST_SZ-1:0]    pipe_wdata = '0;
  logic                  dump_start = 1'b0;
  logic                  dump_ready = 1'b0;
  logic [INST_SZ-1:0]    mem_rdata = '0;
  logic                  mem_read, mem_write;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [INST_SZ-1:0]    mem_wdata, pipe_rdata, dump_data;
  logic [MEM_ADDR_W-1:0] dump_addr;
  logic                  dump_valid, dump_done, busy, pipe_stall;
`ifdef DMEM_ADDR_CHECK_EN
  logic                  addr_err;
`endif

  logic [INST_SZ-1:0] mem     [DEPTH];
  logic [INST_SZ-1:0] ref_mem [DEPTH];
  int checks = 0;
  int failures = 0;

  dmem_dump_arbiter #(.INST_SZ(INST_SZ), .MEM_ADDR_W(MEM_ADDR_W)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_halt(halt),
    .i_pipe_mem_read(pipe_re), .i_pipe_mem_write(pipe_we),
    .i_pipe_addr(pipe_addr), .i_pipe_wdata(pipe_wdata),
    .i_dump_start(dump_start), .i_dump_ready(dump_ready), .i_mem_rdata(mem_rdata),
    .o_mem_read(mem_read), .o_mem_write(mem_write), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_pipe_rdata(pipe_rdata), .o_dump_data(dump_data), .o_dump_addr(dump_addr),
    .o_dump_valid(dump_valid), .o_dump_done(dump_done), .o_busy(busy),
`ifdef DMEM_ADDR_CHECK_EN
    .o_addr_err(addr_err),
`endif
    .o_pipe_stall(pipe_stall)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM, read data one cycle after the read strobe
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
    if (mem_read)  mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic pipe_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    halt = 1'b0; pipe_re = 1'b0; pipe_we = 1'b1; pipe_addr = addr; pipe_wdata = data;
    #1;
    chk("pw_write", 64'(mem_write), 64'd1);
    chk("pw_addr", 64'(mem_addr), 64'(addr / 4));
    chk("pw_wdata", 64'(mem_wdata), 64'(data));
    chk("pw_stall", 64'(pipe_stall), 64'd0);
    ref_mem[(addr / 4) % DEPTH] = data;
    @(posedge clk); #1;
    pipe_we = 1'b0;
  endtask

  task automatic pipe_read(input logic [31:0] addr);
    @(negedge clk);
    halt = 1'b0; pipe_we = 1'b0; pipe_re = 1'b1; pipe_addr = addr;
    #1;
    chk("pr_read", 64'(mem_read), 64'd1);
    chk("pr_addr", 64'(mem_addr), 64'(addr / 4));
    @(posedge clk); #1;
    pipe_re = 1'b0;
    chk("pr_rdata", 64'(pipe_rdata), 64'(ref_mem[(addr / 4) % DEPTH]));
  endtask

  // mode 0: ready always high, 1: random ready, 2: five-cycle stall at word 7
  task automatic run_dump(input int mode, input int abort_addr);
    int   beat = 0;
    int   cyc = 0;
    int   dones = 0;
    int   stall = 0;
    logic aborted = 1'b0;
    logic prev_hold = 1'b0;
    logic [31:0] prev_data = '0;
    logic [4:0]  prev_addr = '0;
    @(negedge clk);
    pipe_we = 1'b0; pipe_re = 1'b0; halt = 1'b1; dump_start = 1'b1; dump_ready = 1'b0;
    @(negedge clk);
    dump_start = 1'b0;
    cyc = 1;
    while (cyc < 1000 && dones == 0 && !aborted) begin
      pipe_we = 1'($urandom_range(0, 1)); pipe_re = 1'($urandom_range(0, 1));
      pipe_addr = $urandom; pipe_wdata = $urandom;
      dump_start = 1'($urandom_range(0, 1));
      case (mode)
        0: dump_ready = 1'b1;
        1: dump_ready = 1'($urandom_range(0, 1));
        default: begin
          if (dump_valid && dump_addr == 5'd7 && stall < 5) begin
            dump_ready = 1'b0; stall++;
          end else dump_ready = 1'b1;
        end
      endcase
      #1;
      chk("dump_busy", 64'({busy, pipe_stall}), 64'd3);
      chk("dump_no_pipe_write", 64'(mem_write), 64'd0);
      if (prev_hold) begin
        chk("hold_valid", 64'(dump_valid), 64'd1);
        chk("hold_data", 64'(dump_data), 64'(prev_data));
        chk("hold_addr", 64'(dump_addr), 64'(prev_addr));
      end
      if (mode == 2 && dump_valid && !dump_ready) chk("stall_data28", 64'(dump_data), 64'd28);
      if (dump_done) begin
        dones++;
        chk("done_after_all_beats", 64'(beat), 64'(DEPTH));
        if (mode == 0) chk("done_cycle", 64'(cyc), 64'd97);
      end
      if (abort_addr >= 0 && dump_valid && dump_addr == 5'(abort_addr)) begin
        halt = 1'b0; pipe_we = 1'b0; pipe_re = 1'b0; aborted = 1'b1;
      end
      if (dump_valid && dump_ready && !aborted) begin
        chk("beat_addr", 64'(dump_addr), 64'(beat));
        chk("beat_data", 64'(dump_data), 64'(ref_mem[beat % DEPTH]));
        beat++;
      end
      prev_hold = dump_valid && !dump_ready;
      prev_data = dump_data;
      prev_addr = dump_addr;
      @(negedge clk);
      cyc++;
    end
    pipe_we = 1'b0; pipe_re = 1'b0; dump_start = 1'b0; dump_ready = 1'b0;
    if (!aborted && dones == 0) chk("dump_timeout", 64'd0, 64'd1);
    #1;
    chk("post_dump_idle", 64'({busy, dump_valid, dump_done, pipe_stall}), 64'd0);
    if (aborted) begin
      chk("abort_beats", 64'(beat), 64'(abort_addr));
      dones = 0;
      repeat (20) begin
        @(negedge clk); #1;
        if (dump_done || busy) dones++;
      end
      chk("abort_no_done", 64'(dones), 64'd0);
    end
  endtask

  initial begin
    #1;
    chk("reset_outputs", 64'({dump_data, dump_addr, dump_valid, dump_done, busy, pipe_stall}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Store then load through the pipeline path
    pipe_write(32'h0000_000C, 32'hDEAD_BEEF);
    pipe_read(32'h0000_000C);

    // Start request without halt is ignored
    @(negedge clk);
    halt = 1'b0; dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0; #1;
    chk("start_no_halt", 64'({busy, pipe_stall}), 64'd0);

    for (int k = 0; k < int'(DEPTH); k++) pipe_write(32'(k * 4), 32'(k * 4));
    run_dump(0, -1);
    run_dump(2, -1);

    // Random pipeline traffic reshapes memory before a randomly throttled dump
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1) pipe_write({25'd0, 5'($urandom), 2'b00}, $urandom);
      else pipe_read({25'd0, 5'($urandom), 2'b00});
    end
    run_dump(1, -1);
    run_dump(1, 10);

    // Asynchronous reset during SEND
    @(negedge clk);
    halt = 1'b1; dump_start = 1'b1; dump_ready = 1'b0;
    @(negedge clk);
    dump_start = 1'b0;
    for (int i = 0; i < 20 && !dump_valid; i++) @(negedge clk);
    chk("reached_send", 64'(dump_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        64'({dump_data, dump_addr, dump_valid, dump_done, busy, pipe_stall, mem_read, mem_write}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; halt = 1'b0; dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("post_reset_idle", 64'({busy, dump_valid, dump_done}), 64'd0);

`ifdef DMEM_ADDR_CHECK_EN
    chk("addr_err_clear", 64'(addr_err), 64'd0);
    @(negedge clk);
    halt = 1'b0; pipe_we = 1'b1; pipe_addr = 32'h0000_0102; pipe_wdata = 32'h1234_5678;
    #1;
    chk("bad_addr_no_write", 64'(mem_write), 64'd0);
    @(negedge clk);
    pipe_we = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("addr_err_sticky", 64'(addr_err), 64'd1);
    pipe_read(32'h0000_0000);
    rst_n = 1'b0; #1;
    chk("addr_err_reset", 64'(addr_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
